// File: rtl/clock_div_prog.sv
// Programmable clock divider with a runtime-programmable period and high-phase length.
// A new setting waits in a shadow register until the next period boundary, or applies at once while counting is stopped.
module clock_div_prog #(
  parameter int WIDTH     = 28,
  parameter int RESET_DIV = 50000000
) (
  input  logic             clock_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             load,
  output logic             clock_out,
  output logic             tick,
  output logic             load_ack,
  output logic             busy
);

  // state   | meaning
  // IDLE    | no setting waiting; D/H in use are the latest
  // PENDING | shadow holds a setting not yet applied to D/H
  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] RST_H = WIDTH'(RESET_DIV / 2);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] d_act;
  logic [WIDTH-1:0] h_act;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] h_sh;
  logic [WIDTH-1:0] div_san;
  logic [WIDTH-1:0] high_san;
  logic             wrap;
  logic             apply;
  logic             capture;

  always_comb begin
    div_san  = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
    high_san = (high_in > div_san) ? div_san : high_in;
    wrap     = enable && (cnt == d_act - WIDTH'(1));
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load arriving on the application edge refills the shadow after the old
  // value is consumed, so it is never applied on its own capture edge.
  always_comb begin
    state_next = state;
    apply      = 1'b0;
    capture    = load;
    case (state)
      IDLE: begin
        if (load) state_next = PENDING;
      end
      PENDING: begin
        if (wrap || !enable) begin
          apply      = 1'b1;
          state_next = load ? PENDING : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == PENDING);

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      d_act     <= RST_D;
      h_act     <= RST_H;
      d_sh      <= RST_D;
      h_sh      <= RST_H;
      clock_out <= 1'b0;
      tick      <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      tick     <= wrap;
      load_ack <= apply;
      if (capture) begin
        d_sh <= div_san;
        h_sh <= high_san;
      end
      if (enable) begin
        clock_out <= (cnt < h_act);
      end
      if (apply) begin
        d_act <= d_sh;
        h_act <= h_sh;
        cnt   <= '0;
      end else if (wrap) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Testbench for clock_div_prog with WIDTH=8, RESET_DIV=10.
// Stimulus queues the expected tick period/high counts and load_ack cycles; a monitor checks them as outputs appear.
module tb_clock_div_prog;

  localparam int W = 8;

  logic         clock_in = 1'b0;
  logic         rst_n    = 1'b0;
  logic         enable   = 1'b1;
  logic         load     = 1'b0;
  logic [W-1:0] div_in   = '0;
  logic [W-1:0] high_in  = '0;
  logic         clock_out;
  logic         tick;
  logic         load_ack;
  logic         busy;

  clock_div_prog #(.WIDTH(W), .RESET_DIV(10)) dut (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .enable   (enable),
    .div_in   (div_in),
    .high_in  (high_in),
    .load     (load),
    .clock_out(clock_out),
    .tick     (tick),
    .load_ack (load_ack),
    .busy     (busy)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int period;
    int high;
  } tick_exp_t;

  tick_exp_t tick_q[$];
  int        ack_q[$];
  tick_exp_t te;
  int        tests = 0;
  int        fails = 0;
  int        smp = 0;
  int        per = 0;
  int        hi  = 0;
  int        e   = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ticks(input int n, input int p, input int h);
    tick_exp_t t;
    t.period = p;
    t.high   = h;
    for (int i = 0; i < n; i++) tick_q.push_back(t);
  endtask

  // e counts enabled-or-not clock edges since the last reset release
  task automatic goto_edge(input int k);
    while (e < k) begin
      @(negedge clock_in);
      e++;
    end
  endtask

  // monitor: sample index smp equals the number of edges since reset release
  always @(negedge clock_in) begin
    if (!rst_n) begin
      smp = 0;
      per = 0;
      hi  = 0;
    end else begin
      smp++;
      per++;
      if (clock_out) hi++;
      if (load_ack) begin
        tests++;
        if (ack_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ack: load_ack seen at cycle %0d, none expected", smp);
        end else if (smp != ack_q[0]) begin
          fails++;
          $display("FAIL ack_cycle: got %0d, expected %0d", smp, ack_q[0]);
          void'(ack_q.pop_front());
        end else begin
          void'(ack_q.pop_front());
        end
      end
      if (tick) begin
        if (tick_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tick: tick at cycle %0d, none expected", smp);
        end else begin
          te = tick_q.pop_front();
          check("tick_period", per, te.period);
          check("tick_high", hi, te.high);
        end
        per = 0;
        hi  = 0;
      end
    end
  end

  initial begin
    // expected ticks (period, high) in order, and load_ack cycles
    push_ticks(4, 10, 5);   // reset setting, last one is the (4,1) apply edge
    push_ticks(4, 4, 1);    // D=4 H=1, last one is the (0,7) apply edge
    push_ticks(4, 2, 2);    // D=2 H=2 constant high, last is the (10,5) apply edge
    push_ticks(1, 13, 8);   // enable dropped for 3 cycles at cnt=4
    push_ticks(1, 10, 5);   // (6,3)/(8,2) apply edge
    push_ticks(2, 8, 2);    // D=8 H=2
    push_ticks(3, 10, 5);   // after reset during pending load
    ack_q.push_back(40);
    ack_q.push_back(56);
    ack_q.push_back(64);
    ack_q.push_back(87);

    rst_n  = 1'b0;
    enable = 1'b1;
    #2;
    check("reset_outputs", {clock_out, tick, load_ack, busy}, 0);
    #10 rst_n = 1'b1;
    e = 0;
    goto_edge(5);
    check("busy_idle", busy, 0);

    goto_edge(33);
    div_in = 8'd4; high_in = 8'd1; load = 1'b1;
    goto_edge(34);
    load = 1'b0;
    check("busy_after_load", busy, 1);
    goto_edge(39);
    check("busy_before_wrap", busy, 1);
    goto_edge(40);
    check("busy_after_apply", busy, 0);

    goto_edge(52);
    div_in = 8'd0; high_in = 8'd7; load = 1'b1;
    goto_edge(53);
    load = 1'b0;
    check("busy_sanitised_load", busy, 1);

    // load coincides with the wrap at edge 62; must not apply until edge 64
    goto_edge(61);
    div_in = 8'd10; high_in = 8'd5; load = 1'b1;
    goto_edge(62);
    load = 1'b0;
    check("busy_load_on_wrap", busy, 1);
    goto_edge(63);
    check("busy_still_pending", busy, 1);
    goto_edge(64);
    check("busy_cleared", busy, 0);

    goto_edge(68);
    enable = 1'b0;
    goto_edge(71);
    enable = 1'b1;

    goto_edge(78);
    div_in = 8'd6; high_in = 8'd3; load = 1'b1;
    goto_edge(79);
    load = 1'b0;
    goto_edge(80);
    div_in = 8'd8; high_in = 8'd2; load = 1'b1;
    goto_edge(81);
    load = 1'b0;
    check("busy_double_load", busy, 1);
    goto_edge(87);
    check("busy_after_double", busy, 0);

    goto_edge(103);
    div_in = 8'd4; high_in = 8'd1; load = 1'b1;
    goto_edge(104);
    load = 1'b0;
    goto_edge(105);
    check("pre_reset_state", {clock_out, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {clock_out, tick, load_ack, busy}, 0);
    repeat (2) @(negedge clock_in);
    #2 rst_n = 1'b1;
    e = 0;
    goto_edge(31);
    check("busy_after_reset", busy, 0);
    goto_edge(33);

    check("ticks_left", tick_q.size(), 0);
    check("acks_left", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
